// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU control path: opcodes, ALU selects,
// sequencer states and instruction field positions.
package cpu_pkg;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 2;
  localparam int RS_MSB  = 1;
  localparam int RS_LSB  = 0;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_CMP  = 4'b0010;
  localparam logic [3:0] OP_SUBR = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_LDI  = 4'b1000;
  localparam logic [3:0] OP_JMP  = 4'b1001;
  localparam logic [3:0] OP_JZ   = 4'b1010;
  localparam logic [3:0] OP_NOP  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_CMP  = 3'b010;
  localparam logic [2:0] ALU_SUBR = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_AND  = 3'b110;
  localparam logic [2:0] ALU_XOR  = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_IMM    = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

endpackage

// File: rtl/cpu_control_unit_if.sv
// Fetch handshake and datapath control bus; master is the control unit,
// slave is the memory/register-file/ALU side.
interface cpu_control_unit_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        InstrData;
  logic              InstrValid;
  logic              InstrReq;
  logic [ADDR_W-1:0] PC;
  logic [2:0]        ALUSel;
  logic              ZFlag;
  logic [1:0]        RdAddr;
  logic [1:0]        RsAddr;
  logic              RegWrite;
  logic              ALUSrcImm;
  logic [7:0]        ImmData;
  logic              ZLatched;
  logic              Halted;

  modport master (
    input  InstrData, InstrValid, ZFlag,
    output InstrReq, PC, ALUSel, RdAddr, RsAddr, RegWrite, ALUSrcImm,
           ImmData, ZLatched, Halted
  );

  modport slave (
    output InstrData, InstrValid, ZFlag,
    input  InstrReq, PC, ALUSel, RdAddr, RsAddr, RegWrite, ALUSrcImm,
           ImmData, ZLatched, Halted
  );
endinterface

// File: rtl/cpu_instr_decode.sv
// Purely combinational instruction decoder: splits the instruction register
// into fields and classifies the opcode.
module cpu_instr_decode
  import cpu_pkg::*;
(
  input  logic [7:0] ir_i,
  output logic [2:0] alu_sel_o,
  output logic [1:0] rd_o,
  output logic [1:0] rs_o,
  output logic       is_alu_o,
  output logic       is_cmp_o,
  output logic       needs_imm_o,
  output logic       is_ldi_o,
  output logic       is_jmp_o,
  output logic       is_jz_o,
  output logic       is_halt_o,
  output logic       is_illegal_o
);

  logic [3:0] opcode;

  assign opcode = ir_i[OPC_MSB:OPC_LSB];
  assign rd_o   = ir_i[RD_MSB:RD_LSB];
  assign rs_o   = ir_i[RS_MSB:RS_LSB];

  always_comb begin
    alu_sel_o    = ALU_ADD;
    is_alu_o     = 1'b0;
    is_cmp_o     = 1'b0;
    is_ldi_o     = 1'b0;
    is_jmp_o     = 1'b0;
    is_jz_o      = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;
    case (opcode)
      OP_ADD:  begin is_alu_o = 1'b1; alu_sel_o = ALU_ADD;  end
      OP_SUB:  begin is_alu_o = 1'b1; alu_sel_o = ALU_SUB;  end
      OP_CMP:  begin is_alu_o = 1'b1; alu_sel_o = ALU_CMP; is_cmp_o = 1'b1; end
      OP_SUBR: begin is_alu_o = 1'b1; alu_sel_o = ALU_SUBR; end
      OP_OR:   begin is_alu_o = 1'b1; alu_sel_o = ALU_OR;   end
      OP_NOR:  begin is_alu_o = 1'b1; alu_sel_o = ALU_NOR;  end
      OP_AND:  begin is_alu_o = 1'b1; alu_sel_o = ALU_AND;  end
      OP_XOR:  begin is_alu_o = 1'b1; alu_sel_o = ALU_XOR;  end
      OP_LDI:  is_ldi_o  = 1'b1;
      OP_JMP:  is_jmp_o  = 1'b1;
      OP_JZ:   is_jz_o   = 1'b1;
      OP_NOP:  ;
      OP_HALT: is_halt_o = 1'b1;
      default: is_illegal_o = 1'b1;
    endcase
  end

  assign needs_imm_o = is_ldi_o | is_jmp_o | is_jz_o;

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
// Define ILLEGAL_TRAP_EN to halt on undefined opcodes (else they act as NOP).
//
// state  | meaning
// FETCH  | request opcode byte at PC until InstrValid
// DECODE | fields from IR, pick EXEC or IMM
// IMM    | request immediate byte at PC until InstrValid
// EXEC   | one-cycle strobes, flag/PC update
// HALT   | terminal, only reset exits
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                reset,
  cpu_control_unit_if.master bus
);

`ifdef ILLEGAL_TRAP_EN
  localparam logic TRAP_ILLEGAL = 1'b1;
`else
  localparam logic TRAP_ILLEGAL = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [7:0]        imm_q, imm_d;
  logic [2:0]        alu_sel_q, alu_sel_d;
  logic              req_q, req_d;
  logic              zlat_q, zlat_d;
  logic              halted_q, halted_d;

  logic              reg_write;
  logic              alu_src_imm;
  logic              accept;
  logic              halt_cond;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] jump_target;

  logic [2:0] dec_alu_sel;
  logic [1:0] dec_rd;
  logic [1:0] dec_rs;
  logic       dec_is_alu;
  logic       dec_is_cmp;
  logic       dec_needs_imm;
  logic       dec_is_ldi;
  logic       dec_is_jmp;
  logic       dec_is_jz;
  logic       dec_is_halt;
  logic       dec_is_illegal;

  cpu_instr_decode u_decode (
    .ir_i         (ir_q),
    .alu_sel_o    (dec_alu_sel),
    .rd_o         (dec_rd),
    .rs_o         (dec_rs),
    .is_alu_o     (dec_is_alu),
    .is_cmp_o     (dec_is_cmp),
    .needs_imm_o  (dec_needs_imm),
    .is_ldi_o     (dec_is_ldi),
    .is_jmp_o     (dec_is_jmp),
    .is_jz_o      (dec_is_jz),
    .is_halt_o    (dec_is_halt),
    .is_illegal_o (dec_is_illegal)
  );

  // The request is registered, so a byte offered while it is low is never taken.
  assign accept      = req_q & bus.InstrValid;
  assign pc_inc      = pc_q + ADDR_W'(1);
  assign jump_target = ADDR_W'(imm_q);
  assign halt_cond   = dec_is_halt | (TRAP_ILLEGAL & dec_is_illegal);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    imm_d       = imm_q;
    alu_sel_d   = alu_sel_q;
    zlat_d      = zlat_q;
    halted_d    = halted_q;
    reg_write   = 1'b0;
    alu_src_imm = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (accept) begin
          ir_d    = bus.InstrData;
          pc_d    = pc_inc;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // ALUSel is loaded here so it is stable for the whole EXEC cycle.
        if (dec_is_alu) begin
          alu_sel_d = dec_alu_sel;
        end
        state_d = dec_needs_imm ? ST_IMM : ST_EXEC;
      end
      ST_IMM: begin
        if (accept) begin
          imm_d   = bus.InstrData;
          pc_d    = pc_inc;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (dec_is_alu) begin
          zlat_d    = bus.ZFlag;
          reg_write = ~dec_is_cmp;
        end else if (dec_is_ldi) begin
          alu_src_imm = 1'b1;
          reg_write   = 1'b1;
        end else if (dec_is_jmp) begin
          pc_d = jump_target;
        end else if (dec_is_jz) begin
          if (zlat_q) begin
            pc_d = jump_target;
          end
        end else if (halt_cond) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase

    req_d = (state_d == ST_FETCH) || (state_d == ST_IMM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      imm_q     <= '0;
      alu_sel_q <= ALU_ADD;
      req_q     <= 1'b0;
      zlat_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      imm_q     <= imm_d;
      alu_sel_q <= alu_sel_d;
      req_q     <= req_d;
      zlat_q    <= zlat_d;
      halted_q  <= halted_d;
    end
  end

  assign bus.InstrReq  = req_q;
  assign bus.PC        = pc_q;
  assign bus.ALUSel    = alu_sel_q;
  assign bus.RdAddr    = dec_rd;
  assign bus.RsAddr    = dec_rs;
  assign bus.RegWrite  = reg_write;
  assign bus.ALUSrcImm = alu_src_imm;
  assign bus.ImmData   = imm_q;
  assign bus.ZLatched  = zlat_q;
  assign bus.Halted    = halted_q;

endmodule
